// File: rtl/subleq_mem_loader.sv
// Framed byte-stream loader for the subleq memory: writes big-endian words and
// holds the CPU in reset until the frame checksum has been verified.
module subleq_mem_loader #(
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned RELEASE_DELAY = 2
) (
    input  logic                  clk,
    input  logic                  areset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  load_start,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  cpu_areset,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [3:0] {
        S_ADDR_HI,
        S_ADDR_LO,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHECK,
        S_RELEASE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic                    armed_q;
    logic [7:0]              hi_q, hi_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]             wdata_q, wdata_d;
    logic [15:0]             count_q, count_d;
    logic [7:0]              sum_q, sum_d;
    logic [7:0]              rel_q, rel_d;
    logic                    ready_state;
    logic                    xfer;

    // armed_q keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= S_ADDR_HI;
            armed_q    <= 1'b0;
            hi_q       <= '0;
            addr_q     <= '0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            count_q    <= '0;
            sum_q      <= '0;
            rel_q      <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= 1'b1;
            hi_q       <= hi_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            rel_q      <= rel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        wdata_d    = wdata_q;
        count_d    = count_q;
        sum_d      = sum_q;
        rel_d      = rel_q;

        ready_state = (state_q == S_ADDR_HI) || (state_q == S_ADDR_LO) ||
                      (state_q == S_CNT_HI)  || (state_q == S_CNT_LO)  ||
                      (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                      (state_q == S_CHECK);
        xfer = in_valid && armed_q && ready_state;

        if (xfer && (state_q != S_CHECK)) begin
            sum_d = sum_q + in_data;
        end

        case (state_q)
            S_ADDR_HI: if (xfer) begin
                hi_d    = in_data;
                state_d = S_ADDR_LO;
            end
            S_ADDR_LO: if (xfer) begin
                addr_d  = ADDR_WIDTH'({hi_q, in_data});
                state_d = S_CNT_HI;
            end
            S_CNT_HI: if (xfer) begin
                hi_d    = in_data;
                state_d = S_CNT_LO;
            end
            S_CNT_LO: if (xfer) begin
                count_d = {hi_q, in_data};
                state_d = ({hi_q, in_data} == 16'd0) ? S_CHECK : S_DATA_HI;
            end
            S_DATA_HI: if (xfer) begin
                hi_d    = in_data;
                state_d = S_DATA_LO;
            end
            S_DATA_LO: if (xfer) begin
                wdata_d    = {hi_q, in_data};
                mem_addr_d = addr_q;
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                count_d = count_q - 16'd1;
                state_d = (count_q == 16'd1) ? S_CHECK : S_DATA_HI;
            end
            S_CHECK: if (xfer) begin
                rel_d   = '0;
                state_d = (in_data == sum_q) ? S_RELEASE : S_ERROR;
            end
            S_RELEASE: begin
                if (rel_q == 8'(RELEASE_DELAY - 1)) begin
                    state_d = S_RUN;
                end else begin
                    rel_d = rel_q + 8'd1;
                end
            end
            S_RUN, S_ERROR: if (load_start) begin
                sum_d   = '0;
                state_d = S_ADDR_HI;
            end
            default: state_d = S_ADDR_HI;
        endcase
    end

    assign in_ready   = armed_q && ready_state;
    assign mem_we     = (state_q == S_WRITE);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_areset = (state_q != S_RUN);
    assign done       = (state_q == S_RUN);
    assign err        = (state_q == S_ERROR);

endmodule

// File: tb/tb_subleq_mem_loader.sv
// Bench for subleq_mem_loader: directed frame table, randomized frames checked
// against a frame-level reference model, and a mid-frame reset sequence.
module tb_subleq_mem_loader;

    localparam int unsigned AW = 16;
    localparam int unsigned RD = 3;

    logic          clk = 1'b0;
    logic          areset_n;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          load_start;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          cpu_areset;
    logic          done;
    logic          err;

    subleq_mem_loader #(.ADDR_WIDTH(AW), .RELEASE_DELAY(RD)) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .load_start (load_start),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_areset (cpu_areset),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] bytes;   // frame, first byte most significant, right-aligned
        int          n;
        int          gap;
        int          nw;
        logic [31:0] w0;      // {addr, data}
        logic [31:0] w1;
        bit          good;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] wq[$];
    logic [31:0] exp_q[$];
    logic [7:0]  frame_q[$];
    bit          exp_good;
    vec_t        tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            wq.push_back({mem_addr, mem_wdata});
            chk("ready_low_in_write", {31'd0, in_ready}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
        chk({tag, "_mem_we"},     {31'd0, mem_we},     32'd0);
        chk({tag, "_mem_addr"},   {16'd0, mem_addr},   32'd0);
        chk({tag, "_mem_wdata"},  {16'd0, mem_wdata},  32'd0);
        chk({tag, "_cpu_areset"}, {31'd0, cpu_areset}, 32'd1);
        chk({tag, "_done"},       {31'd0, done},       32'd0);
        chk({tag, "_err"},        {31'd0, err},        32'd0);
    endtask

    // Stray load_start pulses inside a frame must be ignored.
    task automatic send_byte(input logic [7:0] b, input int gap_max, output bit ok);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        in_valid = 1'b0;
        for (int i = 0; i < g; i++) begin
            if ($urandom_range(7, 0) == 0) load_start = 1'b1;
            tick();
            load_start = 1'b0;
        end
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) tick();
        else chk("byte_accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    function automatic void model_frame();
        logic [15:0] addr;
        int unsigned cnt;
        int unsigned s;
        exp_q.delete();
        addr = {frame_q[0], frame_q[1]};
        cnt  = {frame_q[2], frame_q[3]};
        for (int i = 0; i < int'(cnt); i++)
            exp_q.push_back({16'(addr + i), frame_q[4 + 2*i], frame_q[5 + 2*i]});
        s = 0;
        for (int i = 0; i < frame_q.size() - 1; i++) s += frame_q[i];
        exp_good = (frame_q[frame_q.size() - 1] == s[7:0]);
    endfunction

    task automatic run_frame(input string tag, input int gap);
        bit ok;
        int k;
        wq.delete();
        ok = 1'b1;
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i], gap, ok);
            if (!ok) break;
        end
        if (exp_good) begin
            k = 0;
            while (!done && k < int'(RD) + 5) begin
                chk({tag, "_cpu_areset_release"}, {31'd0, cpu_areset}, 32'd1);
                tick();
                k++;
            end
            chk({tag, "_release_latency"}, k, RD);
            chk({tag, "_done"},       {31'd0, done},       32'd1);
            chk({tag, "_cpu_areset"}, {31'd0, cpu_areset}, 32'd0);
            chk({tag, "_err"},        {31'd0, err},        32'd0);
            chk({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
        end else begin
            chk({tag, "_err"},        {31'd0, err},        32'd1);
            chk({tag, "_done"},       {31'd0, done},       32'd0);
            chk({tag, "_cpu_areset"}, {31'd0, cpu_areset}, 32'd1);
            chk({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
            repeat (RD + 2) tick();
            chk({tag, "_err_held"},   {31'd0, err},        32'd1);
            chk({tag, "_cpu_areset_held"}, {31'd0, cpu_areset}, 32'd1);
        end
        chk({tag, "_write_count"}, wq.size(), exp_q.size());
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
            chk({tag, "_write"}, wq[i], exp_q[i]);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk({tag, "_restart_done"},       {31'd0, done},       32'd0);
        chk({tag, "_restart_err"},        {31'd0, err},        32'd0);
        chk({tag, "_restart_cpu_areset"}, {31'd0, cpu_areset}, 32'd1);
        chk({tag, "_restart_in_ready"},   {31'd0, in_ready},   32'd1);
    endtask

    task automatic load_vec(input vec_t v);
        frame_q.delete();
        for (int i = 0; i < v.n; i++) frame_q.push_back(v.bytes[8*(v.n-1-i) +: 8]);
        exp_q.delete();
        if (v.nw > 0) exp_q.push_back(v.w0);
        if (v.nw > 1) exp_q.push_back(v.w1);
        exp_good = v.good;
    endtask

    initial begin
        tbl[0] = '{96'h0010_0002_1234_ABCD_D0, 9, 0, 2, 32'h0010_1234, 32'h0011_ABCD, 1'b1};
        tbl[1] = '{96'h0010_0002_1234_ABCD_D1, 9, 0, 2, 32'h0010_1234, 32'h0011_ABCD, 1'b0};
        tbl[2] = '{96'hFFFF_0002_0001_0002_03, 9, 0, 2, 32'hFFFF_0001, 32'h0000_0002, 1'b1};
        tbl[3] = '{96'h0000_0000_00,           5, 0, 0, 32'h0,         32'h0,         1'b1};
        tbl[4] = '{96'h0010_0002_1234_ABCD_D0, 9, 4, 2, 32'h0010_1234, 32'h0011_ABCD, 1'b1};

        areset_n   = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        load_start = 1'b0;
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        areset_n = 1'b1;
        #1;
        chk("por_ready_before_edge", {31'd0, in_ready}, 32'd0);
        tick();
        chk("por_ready_after_edge", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            load_vec(tbl[i]);
            run_frame($sformatf("vec%0d", i), tbl[i].gap);
        end

        for (int r = 0; r < 20; r++) begin
            logic [15:0] a;
            logic [7:0]  s;
            int          cnt;
            frame_q.delete();
            a   = ($urandom_range(3, 0) == 0) ? 16'hFFFE : 16'($urandom);
            cnt = $urandom_range(4, 0);
            frame_q.push_back(a[15:8]);
            frame_q.push_back(a[7:0]);
            frame_q.push_back(8'h00);
            frame_q.push_back(8'(cnt));
            for (int i = 0; i < 2*cnt; i++) frame_q.push_back(8'($urandom));
            s = 8'h00;
            foreach (frame_q[i]) s = s + frame_q[i];
            if ($urandom_range(3, 0) == 0) s = s + 8'($urandom_range(255, 1));
            frame_q.push_back(s);
            model_frame();
            run_frame($sformatf("rnd%0d", r), 3);
        end

        load_vec(tbl[0]);
        for (int i = 0; i < 5; i++) begin
            bit ok;
            send_byte(frame_q[i], 0, ok);
        end
        wq.delete();
        in_valid = 1'b1;
        in_data  = 8'h34;
        #2;
        areset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) tick();
        chk("midreset_no_writes", wq.size(), 0);
        in_valid = 1'b0;
        @(negedge clk);
        areset_n = 1'b1;
        #1;
        chk("midreset_ready_before_edge", {31'd0, in_ready}, 32'd0);
        tick();
        chk("midreset_ready_after_edge", {31'd0, in_ready}, 32'd1);
        load_vec(tbl[0]);
        run_frame("after_reset", 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
